// File: rtl/divider_pkg.sv
// Shared widths and state encoding for the sequential signed divider.
package divider_pkg;

  localparam int unsigned DIV_WIDTH = 64;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/divider_step.sv
// One combinational radix-2 restoring iteration: shift in a dividend bit,
// trial-subtract the divisor magnitude, keep or restore.
module div_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_c_o,
  output logic             q_bit_c_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The stored remainder is always below |divisor|, so WIDTH+1 bits of
  // shifted value cannot overflow and the result fits back into WIDTH bits.
  always_comb begin
    shifted   = {rem_i, bit_i};
    diff      = shifted - {1'b0, divisor_i};
    q_bit_c_o = ~diff[WIDTH];
    rem_c_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/divider.sv
// Sequential 64-bit signed divider, one restoring iteration per clock,
// sharing the op_start / op_clear / op_done handshake of the multiplier.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             op_start,
  input  logic             op_clear,
  output logic             op_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmdr_q, rmdr_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_c_o   (step_rem),
    .q_bit_c_o (step_q)
  );

  // dvd_q shifts dividend bits out of the top while quotient bits enter below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quot_d  = quot_q;
    rmdr_d  = rmdr_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    q_mag   = {dvd_q[WIDTH-2:0], step_q};

    if (op_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      quot_d  = '0;
      rmdr_d  = '0;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_start) begin
            if (divisor == '0) begin
              state_d = DONE;
              quot_d  = '1;
              rmdr_d  = dividend;
              done_d  = 1'b1;
              dbz_d   = 1'b1;
            end else begin
              state_d = EXEC;
              dvd_d   = dividend[WIDTH-1] ? -dividend : dividend;
              dvs_d   = divisor[WIDTH-1] ? -divisor : divisor;
              q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_neg_d = dividend[WIDTH-1];
              rem_d   = '0;
              cnt_d   = '0;
            end
          end
        end
        EXEC: begin
          rem_d = step_rem;
          dvd_d = q_mag;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            quot_d  = q_neg_q ? -q_mag : q_mag;
            rmdr_d  = r_neg_q ? -step_rem : step_rem;
          end
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= '0;
      rmdr_q  <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quot_q  <= quot_d;
      rmdr_q  <= rmdr_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign op_done     = done_q;
  assign quotient    = quot_q;
  assign remainder   = rmdr_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the signed divider: stimulus pushes expected results,
// a monitor pops and compares on every rising op_done.
module tb_divider;

  logic        clk;
  logic        reset;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        op_start;
  logic        op_clear;
  logic        op_done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic done_prev = 1'b0;

  divider dut (
    .clk         (clk),
    .reset       (reset),
    .dividend    (dividend),
    .divisor     (divisor),
    .op_start    (op_start),
    .op_clear    (op_clear),
    .op_done     (op_done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Monitor: compare against the scoreboard whenever results become valid.
  always @(negedge clk) begin
    if (op_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected op_done", 64'(op_done), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
      end
    end
    done_prev = op_done;
  end

  // Issue a divide and measure edges after the start edge until op_done.
  task automatic start_div(input logic [63:0] dd, input logic [63:0] dv,
                           input logic [63:0] eq, input logic [63:0] er,
                           input logic edbz, input int exp_edges, input string tag);
    int n;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    op_start = 1'b1;
    exp_q.push_back('{eq, er, edbz});
    @(posedge clk); #1;
    n = 0;
    while (!op_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_edges));
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    op_start = 1'b0;
    op_clear = 1'b1;
    @(posedge clk); #1;
    check({tag, " done after clear"}, 64'(op_done), 64'd0);
    check({tag, " quotient after clear"}, quotient, 64'd0);
    @(negedge clk);
    op_clear = 1'b0;
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    dividend = '0;
    divisor  = '0;
    op_start = 1'b0;
    op_clear = 1'b0;
    #1;
    check("reset op_done", 64'(op_done), 64'd0);
    check("reset quotient", quotient, 64'd0);
    check("reset remainder", remainder, 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 100/7 with op_start held through DONE
    start_div(64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 64, "100/7");
    repeat (3) @(posedge clk);
    #1;
    check("held start stays done", 64'(op_done), 64'd1);
    check("held start quotient", quotient, 64'd14);
    do_clear("c1");

    start_div(-64'sd100, 64'd7, -64'sd14, -64'sd2, 1'b0, 64, "-100/7");
    do_clear("c2");
    start_div(64'd100, -64'sd7, -64'sd14, 64'd2, 1'b0, 64, "100/-7");
    do_clear("c3");
    start_div(-64'sd100, -64'sd7, 64'd14, -64'sd2, 1'b0, 64, "-100/-7");
    do_clear("c4");

    start_div(64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 0, "5/0");
    do_clear("c5");
    start_div(-64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, -64'sd7, 1'b1, 0, "-7/0");
    do_clear("c6");
    start_div(64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 64, "min/-1");
    do_clear("c7");
    start_div(64'd3, 64'd10, 64'd0, 64'd3, 1'b0, 64, "3/10");
    do_clear("c8");
    start_div(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64, "max/1");
    do_clear("c9");

    // Operand changes mid-EXEC and op_start pulses in DONE are ignored.
    @(negedge clk);
    dividend = 64'd1000;
    divisor  = 64'd7;
    op_start = 1'b1;
    exp_q.push_back('{64'd142, 64'd6, 1'b0});
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    dividend = -64'sd1234;
    divisor  = 64'd3;
    n = 0;
    while (!op_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("1000/7 finished", 64'(op_done), 64'd1);
    @(negedge clk);
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pulse in DONE done", 64'(op_done), 64'd1);
    check("pulse in DONE quotient", quotient, 64'd142);
    do_clear("c10");

    // op_clear at EXEC cycle 30 aborts the operation.
    @(negedge clk);
    dividend = 64'd100;
    divisor  = 64'd7;
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk); #1;
    check("abort op_done", 64'(op_done), 64'd0);
    check("abort remainder", remainder, 64'd0);
    check("abort div_by_zero", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    op_clear = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("abort stays idle", 64'(op_done), 64'd0);

    // Reset at EXEC cycle 40, then a normal divide.
    @(negedge clk);
    op_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_start = 1'b0;
    repeat (39) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid reset op_done", 64'(op_done), 64'd0);
    check("mid reset quotient", quotient, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("reset stays idle", 64'(op_done), 64'd0);
    start_div(64'd7, 64'd2, 64'd3, 64'd1, 1'b0, 64, "7/2");
    @(negedge clk);
    op_start = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("done reset op_done", 64'(op_done), 64'd0);
    check("done reset quotient", quotient, 64'd0);
    check("done reset remainder", remainder, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    repeat (3) @(posedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
